// File: rtl/i2s_receiver_pkg.sv
// Shared audio constants for the I2S front end and the meter's channel branch.
package i2s_receiver_pkg;

    localparam int   AUDIO_WIDTH = 16;
    localparam int   BIT_CNT_W   = 6;
    localparam logic I2S_LEFT    = 1'b0;

    typedef enum logic {
        RX_IDLE,
        RX_ARMED
    } rx_state_e;

endpackage

// File: rtl/i2s_receiver_sync_edge_detect.sv
// Two-flop synchroniser with a history flop; flags a rising edge of the synchronised input.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1, sync2, hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S stereo deserialiser oversampled on clk, presenting a valid/ready sample stream.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int width       = AUDIO_WIDTH,
    parameter int count_width = BIT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_is_left,
    output logic [width-1:0] o_audio,
    output logic             o_overrun
);

    logic                   bclk_rise;
    logic [1:0]             lr_sync;
    logic [1:0]             d_sync;
    logic                   lrclk_s, data_s;
    logic                   lrclk_prev;
    rx_state_e              state;
    logic                   channel;
    logic [count_width-1:0] bit_cnt;
    logic [width-1:0]       shift;
    logic                   lr_change;
    logic                   word_done;

    sync_edge_detect u_bclk (
        .clk   (clk),
        .reset (reset),
        .din   (i2s_bclk),
        .rise  (bclk_rise)
    );

    assign lrclk_s   = lr_sync[1];
    assign data_s    = d_sync[1];
    assign lr_change = (lrclk_s != lrclk_prev);
    // The final bit of an exactly-width slot arrives on the LRCK change edge itself,
    // so completion is judged on the count alone, before the transition rearms.
    assign word_done = (state == RX_ARMED) && (bit_cnt == count_width'(width - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            lr_sync    <= '0;
            d_sync     <= '0;
            lrclk_prev <= 1'b0;
            state      <= RX_IDLE;
            channel    <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            o_valid    <= 1'b0;
            o_is_left  <= 1'b0;
            o_audio    <= '0;
            o_overrun  <= 1'b0;
        end else begin
            lr_sync   <= {lr_sync[0], i2s_lrclk};
            d_sync    <= {d_sync[0], i2s_data};
            o_overrun <= 1'b0;
            if (o_valid && o_ready)
                o_valid <= 1'b0;

            if (bclk_rise) begin
                lrclk_prev <= lrclk_s;
                if (word_done) begin
                    if (!o_valid || o_ready) begin
                        o_audio   <= {shift[width-2:0], data_s};
                        o_is_left <= (channel == I2S_LEFT);
                        o_valid   <= 1'b1;
                    end else begin
                        o_overrun <= 1'b1;
                    end
                end
                if (lr_change) begin
                    channel <= lrclk_s;
                    bit_cnt <= '0;
                    state   <= RX_ARMED;
                end else if (state == RX_ARMED && bit_cnt < count_width'(width)) begin
                    shift   <= {shift[width-2:0], data_s};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
